// File: rtl/dmem_dump_engine.sv
// dmem_dump_engine
//   Owns the end-of-run data memory dump. When the halt instruction reaches
//   the memory stage, or a dump is explicitly requested, the core is frozen.
//   The engine then reads every word from address 0 to DEPTH-1 and streams
//   each (address, word) pair out on a valid/ready interface.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   mem_instr    instruction currently in the memory stage
//   dump_req     force a dump without a halt instruction (level, sampled in IDLE)
//   halted       core freeze, sticky until rst
//   mem_rd_en    data memory read strobe
//   mem_rd_addr  data memory read address
//   mem_rd_data  read data, valid the cycle after mem_rd_en
//   out_valid    dump word available
//   out_ready    sink accepts word
//   out_addr     address of dumped word
//   out_data     dumped word
//   busy         dump in progress
//   done         all DEPTH words accepted, sticky until rst
//
// State table
//   state  | meaning
//   IDLE   | waiting for halt opcode or dump_req
//   READ   | one-cycle read strobe at ptr
//   WAIT   | synchronous RAM latency; capture word and address
//   OUT    | word presented to sink until accepted
//   DONE   | whole memory dumped; parked until rst
module dmem_dump_engine #(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 8,
  parameter int          DEPTH       = 256,
  parameter logic [15:0] HALT_OPCODE = 16'hF000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       mem_instr,
  input  logic              dump_req,
  output logic              halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  // Exact compare against the last address; with DEPTH = 2^ADDR_W this is
  // the all-ones pointer, so the pointer never needs to wrap.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                trigger;

  assign trigger = (mem_instr == HALT_OPCODE) || dump_req;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == S_WAIT) begin
        out_addr_q <= ptr_q;
        out_data_q <= mem_rd_data;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_READ;
          ptr_d   = '0;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (ptr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    halted    = 1'b0;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_READ: begin
        halted    = 1'b1;
        busy      = 1'b1;
        mem_rd_en = 1'b1;
      end
      S_WAIT: begin
        halted = 1'b1;
        busy   = 1'b1;
      end
      S_OUT: begin
        halted    = 1'b1;
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      S_DONE: begin
        halted = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  // ptr only advances on the edge that enters READ, so it already equals
  // the last address read in every other state.
  assign mem_rd_addr = ptr_q;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;

endmodule

// File: tb/tb_dmem_dump_engine.sv
module tb_dmem_dump_engine;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       mem_instr;
  logic              dump_req;
  logic              halted;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  dmem_dump_engine #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .HALT_OPCODE(16'hF000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_instr(mem_instr),
    .dump_req(dump_req),
    .halted(halted),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_data(out_data),
    .busy(busy),
    .done(done)
  );

  // Synchronous RAM model
  logic [DATA_W-1:0] mem [0:255];
  logic [DATA_W-1:0] exp_data [0:3];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Read strobe and handshake counters
  int rd_cnt = 0;
  int hs_cnt = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (mem_rd_en) rd_cnt++;
      if (out_valid && out_ready) hs_cnt++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int rd_base;
  int hs_base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_halted"},   halted,      0);
    check({tag, "_rd_en"},    mem_rd_en,   0);
    check({tag, "_rd_addr"},  mem_rd_addr, 0);
    check({tag, "_valid"},    out_valid,   0);
    check({tag, "_out_addr"}, out_addr,    0);
    check({tag, "_out_data"}, out_data,    0);
    check({tag, "_busy"},     busy,        0);
    check({tag, "_done"},     done,        0);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"},   done,      1);
    check({tag, "_busy"},   busy,      0);
    check({tag, "_halted"}, halted,    1);
    check({tag, "_valid"},  out_valid, 0);
    check({tag, "_rd_en"},  mem_rd_en, 0);
  endtask

  // Entered in the READ cycle of word i; returns one cycle after the handshake
  // edge (or after the reset edge when abort is set).
  task automatic run_word(input int i, input int stall, input bit pulse_req, input bit abort);
    if (pulse_req) dump_req = 1'b1;
    check("read_rd_en",   mem_rd_en,   1);
    check("read_rd_addr", mem_rd_addr, i);
    check("read_valid",   out_valid,   0);
    check("read_busy",    busy,        1);
    check("read_halted",  halted,      1);
    tick();
    dump_req = 1'b0;
    check("wait_rd_en", mem_rd_en, 0);
    check("wait_valid", out_valid, 0);
    tick();
    check("out_valid", out_valid, 1);
    check("out_addr",  out_addr,  i);
    check("out_data",  out_data,  exp_data[i]);
    check("out_rd_en", mem_rd_en, 0);
    if (abort) begin
      rst = 1'b1;
      tick();
      check_all_zero("abort");
      rst = 1'b0;
      return;
    end
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        tick();
        check("stall_valid",  out_valid, 1);
        check("stall_addr",   out_addr,  i);
        check("stall_data",   out_data,  exp_data[i]);
        check("stall_rd_en",  mem_rd_en, 0);
        check("stall_halted", halted,    1);
      end
      out_ready = 1'b1;
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    exp_data[0] = 16'h1111;
    exp_data[1] = 16'h2222;
    exp_data[2] = 16'h3333;
    exp_data[3] = 16'h4444;

    // Reset with halt opcode present: nothing happens until rst drops
    rst       = 1'b1;
    mem_instr = 16'hF000;
    dump_req  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_all_zero("rst1");
    tick();
    check_all_zero("rst2");
    rst = 1'b0;
    check_all_zero("post_rst");
    rd_base = rd_cnt;
    hs_base = hs_cnt;
    tick();
    mem_instr = 16'h0000;

    // Halt-triggered dump, sink always ready
    for (int i = 0; i < DEPTH; i++) run_word(i, 0, 1'b0, 1'b0);
    check_done("halt_done");
    check("halt_rd_pulses",   rd_cnt - rd_base, 4);
    check("halt_handshakes",  hs_cnt - hs_base, 4);

    // Triggers after done are ignored
    rd_base   = rd_cnt;
    mem_instr = 16'hF000;
    dump_req  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_done("post_done");
    end
    mem_instr = 16'h0000;
    dump_req  = 1'b0;
    check("post_done_rd_pulses", rd_cnt - rd_base, 0);

    // dump_req-triggered dump with backpressure on word 1 and a second request
    rst = 1'b1;
    tick();
    check_all_zero("rst3");
    rst       = 1'b0;
    mem_instr = 16'h1234;
    dump_req  = 1'b1;
    rd_base   = rd_cnt;
    hs_base   = hs_cnt;
    tick();
    dump_req = 1'b0;
    run_word(0, 0, 1'b0, 1'b0);
    run_word(1, 5, 1'b1, 1'b0);
    run_word(2, 0, 1'b0, 1'b0);
    run_word(3, 0, 1'b0, 1'b0);
    check_done("req_done");
    check("req_rd_pulses",  rd_cnt - rd_base, 4);
    check("req_handshakes", hs_cnt - hs_base, 4);

    // Reset in the OUT state of word 2, then restart from address 0
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    mem_instr = 16'hF000;
    tick();
    mem_instr = 16'h0000;
    run_word(0, 0, 1'b0, 1'b0);
    run_word(1, 0, 1'b0, 1'b0);
    run_word(2, 0, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("idle_valid",  out_valid, 0);
      check("idle_halted", halted,    0);
      check("idle_rd_en",  mem_rd_en, 0);
    end
    mem_instr = 16'hF000;
    rd_base   = rd_cnt;
    hs_base   = hs_cnt;
    tick();
    mem_instr = 16'h0000;
    for (int i = 0; i < DEPTH; i++) run_word(i, 0, 1'b0, 1'b0);
    check_done("restart_done");
    check("restart_rd_pulses",  rd_cnt - rd_base, 4);
    check("restart_handshakes", hs_cnt - hs_base, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
